skew_mem: RTL and testbench
===========================

SKEW_MEM -- requirements
Module: skew_mem

Interface
REQ-001 Parameter BITS_AB, default 8, operand element width (signed).
REQ-002 Parameter DIM, default 8, array dimension: lanes, rows and columns.
REQ-003 Parameter ROWBITS, default $clog2(DIM), row index width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = BUF (load rows, then skewed drain), 1 = STREAM (skewed pass-through); sampled only on accepted start.
REQ-007 wr_en  input  1  BUF row write strobe.
REQ-008 wr_row  input  ROWBITS  row index for wr_en.
REQ-009 din  input  DIM x BITS_AB signed  row data; BUF write data or STREAM input row.
REQ-010 start  input  1  begin a DIM-row operation.
REQ-011 en  input  1  step enable; low = stall.
REQ-012 dout  output  DIM x BITS_AB signed  registered skewed lanes to the systolic array.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  one-cycle pulse after the final step.
REQ-015 wr_err  output  1  sticky; set by wr_en while busy, cleared only by rst.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 IDLE -> RUN SHALL occur on a rising edge with start=1; mode is latched and step counter k is set to 0 at that edge.
REQ-018 In RUN, each edge with en=1 SHALL perform step k and then increment k; en=0 SHALL hold k, memory, dout and the FSM state.
REQ-019 BUF step k SHALL set dout[r] = M[r][k-r] for 0 <= k-r < DIM, and 0 otherwise.
REQ-020 STREAM step k SHALL capture din as row k when k < DIM, and SHALL set dout[c] = din captured at step k-c for 0 <= k-c < DIM, and 0 otherwise.
REQ-021 In STREAM, the lane-c delay from capture to appearance on dout SHALL be c steps; lane 0 SHALL appear at the same edge as its capture.
REQ-022 The step at k = 2*DIM-2 SHALL be the final step; at that edge the FSM SHALL return to IDLE and done SHALL assert for exactly one cycle.
REQ-023 In IDLE, dout SHALL be 0 from the first edge after leaving RUN.
REQ-024 In IDLE, wr_en=1 SHALL write din into M[wr_row]; any wr_row value is legal.
REQ-025 wr_en and start in the same IDLE cycle SHALL both take effect, and the first drain step SHALL see the new row.
REQ-026 In RUN, wr_en SHALL be ignored: no write, and wr_err is set.
REQ-027 start in RUN SHALL be ignored, with no restart and no error.
REQ-028 mode changes outside an accepted start SHALL have no effect.
REQ-029 Memory M SHALL persist across operations until overwritten or reset.

Reset
REQ-030 While rst=1, at each edge: FSM to IDLE, k to 0, all M entries and STREAM delay stages to 0, dout to all 0, busy/done/wr_err to 0.
REQ-031 Reset mid-RUN SHALL abort the operation with no done pulse; rst SHALL take priority over all inputs.

Structure
REQ-032 Package sa_pkg SHALL hold the default BITS_AB/DIM, the state enum {IDLE, RUN} and the mode enum {BUF, STREAM}.
REQ-033 STREAM lane delays SHALL use one sub-module, skew_delay_line (parameters BITS_AB and DEPTH, with an en input), instantiated DIM times with DEPTH = c.
REQ-034 The step counter SHALL be $clog2(2*DIM) bits wide.

Verification (DIM=4, BITS_AB=8)
REQ-035 Reset, then write rows 0..3 = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, start in BUF with en=1 -> dout after steps 0..6: {1,0,0,0},{2,5,0,0},{3,6,9,0},{4,7,10,13},{0,8,11,14},{0,0,12,15},{0,0,0,16}; done pulses once at step 6, busy falls with it.
REQ-036 STREAM, din rows {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} on steps 0..3 -> dout step 0 = {1,0,0,0}, step 3 = {13,10,7,4}, step 6 = {0,0,0,16}.
REQ-037 BUF run with en low for 3 cycles after step 2 -> dout holds {3,6,9,0} for those cycles, and total done latency grows by exactly 3.
REQ-038 wr_en at step 1 with wr_row=0, din=all 99 -> drain output unchanged from REQ-035, and wr_err = 1 persists until rst.
REQ-039 rst asserted at step 3 -> next cycle dout=0, busy=0, no done; rerun of BUF after reset emits all zeros.
REQ-040 Same-cycle wr_en(row 3 = {7,7,7,7}) + start -> step 3 output lane 3 = 7.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared defaults and enums for the systolic-array operand skew buffer.
package sa_pkg;
  localparam int DEFAULT_BITS_AB = 8;
  localparam int DEFAULT_DIM     = 8;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic {BUF = 1'b0, STREAM = 1'b1} mode_t;
endpackage

// File: rtl/skew_delay_line.sv
// Enabled shift register of DEPTH stages; DEPTH = 0 degenerates to a wire.
module skew_delay_line #(
  parameter int BITS_AB = 8,
  parameter int DEPTH   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [BITS_AB-1:0] d,
  output logic [BITS_AB-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = ^{clk, rst, en};
      assign q        = d;
    end else begin : g_reg
      logic [BITS_AB-1:0] r_stage [DEPTH];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (en) begin
          r_stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/skew_mem.sv
// Row buffer / pass-through that presents DIM operand lanes to a systolic
// array with lane c skewed by c steps.
module skew_mem
  import sa_pkg::*;
#(
  parameter int BITS_AB = DEFAULT_BITS_AB,
  parameter int DIM     = DEFAULT_DIM,
  parameter int ROWBITS = $clog2(DIM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic                           wr_en,
  input  logic [ROWBITS-1:0]             wr_row,
  input  logic [DIM-1:0][BITS_AB-1:0]    din,
  input  logic                           start,
  input  logic                           en,
  output logic [DIM-1:0][BITS_AB-1:0]    dout,
  output logic                           busy,
  output logic                           done,
  output logic                           wr_err
);

  localparam int            KW     = $clog2(2*DIM);
  localparam logic [KW-1:0] K_LAST = KW'(2*DIM-2);

  state_t                      r_state, w_state_next;
  mode_t                       r_mode;
  logic [KW-1:0]               r_k;
  logic                        r_done, r_wr_err;
  logic [DIM-1:0][BITS_AB-1:0] r_dout, w_step;
  logic                        w_accept, w_step_en, w_final;
  logic                        w_wr_idle, w_shift;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step_en    = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (en) begin
          w_step_en = 1'b1;
          if (r_k == K_LAST) begin
            w_final      = 1'b1;
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  assign w_wr_idle = wr_en && (r_state == IDLE);
  assign w_shift   = w_step_en && (r_mode == STREAM);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= '0;
      r_mode   <= BUF;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_done <= w_final;
      if (wr_en && (r_state == RUN)) r_wr_err <= 1'b1;
      if (w_accept) begin
        r_k    <= '0;
        r_mode <= mode_t'(mode);
      end else if (w_step_en) begin
        r_k <= r_k + 1'b1;
      end
      // A stalled RUN holds dout; IDLE forces the lanes back to zero.
      if (w_step_en)              r_dout <= w_step;
      else if (r_state == IDLE)   r_dout <= '0;
    end
  end

  generate
    for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
      logic [DIM-1:0][BITS_AB-1:0] r_row;
      logic [BITS_AB-1:0]          w_buf_val, w_dl_d, w_dl_q;

      always_ff @(posedge clk) begin
        if (rst)                                          r_row <= '0;
        else if (w_wr_idle && (wr_row == ROWBITS'(gi)))   r_row <= din;
      end

      // Lane gi emits element k-gi of its own row while that index is in range.
      always_comb begin
        w_buf_val = '0;
        for (int j = 0; j < DIM; j++) begin
          if (r_k == KW'(gi + j)) w_buf_val = r_row[j];
        end
      end

      assign w_dl_d = (r_k < KW'(DIM)) ? din[gi] : '0;

      skew_delay_line #(
        .BITS_AB (BITS_AB),
        .DEPTH   (gi)
      ) u_delay (
        .clk (clk),
        .rst (rst),
        .en  (w_shift),
        .d   (w_dl_d),
        .q   (w_dl_q)
      );

      assign w_step[gi] = (r_mode == STREAM) ? w_dl_q : w_buf_val;
    end
  endgenerate

  assign dout   = r_dout;
  assign busy   = (r_state == RUN);
  assign done   = r_done;
  assign wr_err = r_wr_err;

endmodule

// File: tb/tb_skew_mem.sv
// Directed bench for skew_mem at DIM=4, BITS_AB=8.
module tb_skew_mem;
  localparam int BITS = 8;
  localparam int DIM  = 4;

  logic                     clk = 1'b0;
  logic                     rst, mode, wr_en, start, en;
  logic [1:0]               wr_row;
  logic [DIM-1:0][BITS-1:0] din;
  logic [DIM-1:0][BITS-1:0] dout;
  logic                     busy, done, wr_err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] buf_exp [7];
  logic [31:0] str_exp [7];

  always #5 clk = ~clk;

  skew_mem #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .wr_en  (wr_en),
    .wr_row (wr_row),
    .din    (din),
    .start  (start),
    .en     (en),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .wr_err (wr_err)
  );

  function automatic logic [31:0] row4(input int a, input int b, input int c, input int d);
    logic [7:0] la, lb, lc, ld;
    la = a[7:0]; lb = b[7:0]; lc = c[7:0]; ld = d[7:0];
    return {ld, lc, lb, la};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    buf_exp[0] = row4(1, 0, 0, 0);   buf_exp[1] = row4(2, 5, 0, 0);
    buf_exp[2] = row4(3, 6, 9, 0);   buf_exp[3] = row4(4, 7, 10, 13);
    buf_exp[4] = row4(0, 8, 11, 14); buf_exp[5] = row4(0, 0, 12, 15);
    buf_exp[6] = row4(0, 0, 0, 16);
    str_exp[0] = row4(1, 0, 0, 0);   str_exp[1] = row4(5, 2, 0, 0);
    str_exp[2] = row4(9, 6, 3, 0);   str_exp[3] = row4(13, 10, 7, 4);
    str_exp[4] = row4(0, 14, 11, 8); str_exp[5] = row4(0, 0, 15, 12);
    str_exp[6] = row4(0, 0, 0, 16);

    rst = 1'b1; mode = 1'b0; wr_en = 1'b0; wr_row = '0; din = '0; start = 1'b0; en = 1'b0;
    tick; tick;
    chk("rst_dout", dout, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_wr_err", 32'(wr_err), 32'h0);
    rst = 1'b0;

    // BUF: load rows 0..2, row 3 together with start
    for (int r = 0; r < 3; r++) begin
      wr_en = 1'b1; wr_row = 2'(r); din = row4(4*r+1, 4*r+2, 4*r+3, 4*r+4);
      tick;
    end
    wr_row = 2'd3; din = row4(13, 14, 15, 16); start = 1'b1; mode = 1'b0; en = 1'b1;
    tick;
    wr_en = 1'b0; start = 1'b0;
    chk("buf_busy_start", 32'(busy), 32'h1);
    for (int k = 0; k < 7; k++) begin
      tick;
      $display("buf step %0d dout=%h busy=%0b done=%0b", k, dout, busy, done);
      chk($sformatf("buf_s%0d", k), dout, buf_exp[k]);
      chk($sformatf("buf_done_s%0d", k), 32'(done), 32'(k == 6));
      chk($sformatf("buf_busy_s%0d", k), 32'(busy), 32'(k != 6));
    end
    tick;
    chk("buf_done_clear", 32'(done), 32'h0);
    chk("buf_idle_dout", dout, 32'h0);

    // STREAM, with mode toggled after the accepted start
    mode = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; mode = 1'b0;
    for (int k = 0; k < 7; k++) begin
      din = (k < 4) ? row4(4*k+1, 4*k+2, 4*k+3, 4*k+4) : row4(55, 55, 55, 55);
      tick;
      $display("stream step %0d dout=%h done=%0b", k, dout, done);
      chk($sformatf("str_s%0d", k), dout, str_exp[k]);
      chk($sformatf("str_done_s%0d", k), 32'(done), 32'(k == 6));
    end
    tick;

    // BUF with 3-cycle stall after step 2
    start = 1'b1; mode = 1'b0;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("stall_s%0d", k), dout, buf_exp[k]);
    end
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick;
      $display("stall cycle %0d dout=%h busy=%0b", s, dout, busy);
      chk($sformatf("stall_hold%0d", s), dout, buf_exp[2]);
      chk($sformatf("stall_busy%0d", s), 32'(busy), 32'h1);
      chk($sformatf("stall_done%0d", s), 32'(done), 32'h0);
    end
    en = 1'b1;
    for (int k = 3; k < 7; k++) begin
      tick;
      chk($sformatf("stall_s%0d", k), dout, buf_exp[k]);
      chk($sformatf("stall_done_s%0d", k), 32'(done), 32'(k == 6));
    end
    tick;

    // write and start while busy are ignored; wr_err is sticky
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wr_en = (k == 1); wr_row = 2'd0; din = row4(99, 99, 99, 99);
      start = (k == 2);
      tick;
      $display("werr step %0d dout=%h wr_err=%0b", k, dout, wr_err);
      chk($sformatf("werr_s%0d", k), dout, buf_exp[k]);
      chk($sformatf("werr_flag_s%0d", k), 32'(wr_err), 32'(k >= 1));
    end
    wr_en = 1'b0; start = 1'b0;
    chk("werr_done", 32'(done), 32'h1);
    tick;
    chk("werr_sticky", 32'(wr_err), 32'h1);
    chk("werr_idle_busy", 32'(busy), 32'h0);

    // reset mid-run at step 3
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("mrst_dout", dout, 32'h0);
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    chk("mrst_wr_err", 32'(wr_err), 32'h0);
    tick;
    chk("mrst_no_done", 32'(done), 32'h0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk($sformatf("zero_s%0d", k), dout, 32'h0);
    end
    chk("zero_done", 32'(done), 32'h1);
    tick;

    // same-cycle write of row 3 and start
    wr_en = 1'b1; wr_row = 2'd3; din = row4(7, 7, 7, 7); start = 1'b1; mode = 1'b0;
    tick;
    wr_en = 1'b0; start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      $display("same step %0d dout=%h", k, dout);
      chk($sformatf("same_s%0d", k), dout, (k >= 3) ? row4(0, 0, 0, 7) : 32'h0);
    end
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
